// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control decoder, datapath and the multiply/divide engine.
// The master drives the strobes and operands; the slave is the engine, which owns HI/LO and the status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             multOp;
    logic             divOp;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divZero;

    modport master (
        output multOp, divOp, opA, opB,
        input  hi, lo, busy, done, divZero
    );

    modport slave (
        input  multOp, divOp, opA, opB,
        output hi, lo, busy, done, divZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) engine owning HI/LO.
// States: IDLE wait for strobe | MULT Booth step | DIV quotient-bit step | FINISH write hi/lo | DZERO flag div-by-zero
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MULT   = 3'd1,
        DIV    = 3'd2,
        FINISH = 3'd3,
        DZERO  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             qm1_q, qm1_d;
    logic             op_div_q, op_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // One guard bit keeps the Booth add/subtract exact even for the most negative multiplicand.
    assign acc_ext   = {acc_q[WIDTH-1], acc_q};
    assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    assign div_shift = {acc_q, work_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand_q};
    assign abs_a     = bus.opA[WIDTH-1] ? (-bus.opA) : bus.opA;
    assign abs_b     = bus.opB[WIDTH-1] ? (-bus.opB) : bus.opB;

    always_comb begin
        booth_sum = acc_ext;
        case ({work_q[0], qm1_q})
            2'b01:   booth_sum = acc_ext + mcand_ext;
            2'b10:   booth_sum = acc_ext - mcand_ext;
            default: booth_sum = acc_ext;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        work_d     = work_q;
        mcand_d    = mcand_q;
        qm1_d      = qm1_q;
        op_div_d   = op_div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.multOp) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    acc_d    = '0;
                    work_d   = bus.opB;
                    mcand_d  = bus.opA;
                    qm1_d    = 1'b0;
                    op_div_d = 1'b0;
                end else if (bus.divOp) begin
                    if (bus.opB == '0) begin
                        state_d = DZERO;
                    end else begin
                        state_d   = DIV;
                        cnt_d     = '0;
                        acc_d     = '0;
                        work_d    = abs_a;
                        mcand_d   = abs_b;
                        op_div_d  = 1'b1;
                        neg_quo_d = bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1];
                        neg_rem_d = bus.opA[WIDTH-1];
                    end
                end
            end
            MULT: begin
                acc_d  = booth_sum[WIDTH:1];
                work_d = {booth_sum[0], work_q[WIDTH-1:1]};
                qm1_d  = work_q[0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = FINISH;
            end
            DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d  = div_trial[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = div_shift[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (op_div_q) begin
                    lo_d = neg_quo_q ? (-work_q) : work_q;
                    hi_d = neg_rem_q ? (-acc_q) : acc_q;
                end else begin
                    hi_d = acc_q;
                    lo_d = work_q;
                end
            end
            DZERO: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                div_zero_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            work_q     <= '0;
            mcand_q    <= '0;
            qm1_q      <= 1'b0;
            op_div_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            mcand_q    <= mcand_d;
            qm1_q      <= qm1_d;
            op_div_q   <= op_div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.divZero = div_zero_q;
endmodule
